// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit CPU: gates execution through a clock enable
// and stops on cycle budget expiry, PC breakpoint or halt request.
module cpu_run_ctrl #(
  parameter int CNT_W          = 16,
  parameter int ADDR_W         = 16,
  parameter int DEFAULT_CYCLES = 30
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [1:0]        Cmd_Op,
  input  logic [CNT_W-1:0]  Cmd_Count,
  input  logic              Halt_Req,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Bp_Enable,
  input  logic [ADDR_W-1:0] Bp_Addr,
  output logic              Cpu_En,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        Stop_Reason,
  output logic [CNT_W-1:0]  Cycle_Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FREE,
    S_RUNN
  } state_e;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_FREE = 2'b01;
  localparam logic [1:0] OP_RUNN = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  localparam logic [1:0] RS_NONE = 2'b00;
  localparam logic [1:0] RS_CNT  = 2'b01;
  localparam logic [1:0] RS_BP   = 2'b10;
  localparam logic [1:0] RS_HALT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEF = CNT_W'(DEFAULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [1:0]       stop_reason_q, stop_reason_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic running;
  logic bp_hit;
  logic cpu_en;
  logic idle_s;
  logic halt_s;
  logic bp_s;

  assign running = (state_q != S_IDLE);
  assign bp_hit  = Bp_Enable & (PC == Bp_Addr) & ~first_q;
  assign cpu_en  = running & ~bp_hit & ~Halt_Req;

  assign idle_s = ~running;
  assign halt_s = running & Halt_Req;
  assign bp_s   = running & ~Halt_Req & bp_hit;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    cycle_count_d = cycle_count_q;
    stop_reason_d = stop_reason_q;
    first_d       = first_q;
    done_d        = 1'b0;
    unique case (1'b1)
      idle_s: begin
        if (Cmd_Valid && Cmd_Op != OP_HALT) begin
          cycle_count_d = '0;
          stop_reason_d = RS_NONE;
          first_d       = 1'b1;
          case (Cmd_Op)
            OP_FREE: state_d = S_FREE;
            OP_RUNN: begin
              state_d     = S_RUNN;
              remaining_d = (Cmd_Count == '0) ? CNT_DEF : Cmd_Count;
            end
            OP_STEP: begin
              state_d     = S_RUNN;
              remaining_d = CNT_ONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      halt_s: begin
        state_d       = S_IDLE;
        stop_reason_d = RS_HALT;
        done_d        = 1'b1;
      end
      bp_s: begin
        state_d       = S_IDLE;
        stop_reason_d = RS_BP;
        done_d        = 1'b1;
      end
      cpu_en: begin
        if (cycle_count_q != CNT_MAX) begin
          cycle_count_d = cycle_count_q + CNT_ONE;
        end
        first_d = 1'b0;
        if (state_q == S_RUNN) begin
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d       = S_IDLE;
            stop_reason_d = RS_CNT;
            done_d        = 1'b1;
          end
        end
      end
      default: state_d = state_q;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      cycle_count_q <= '0;
      stop_reason_q <= RS_NONE;
      first_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      cycle_count_q <= cycle_count_d;
      stop_reason_q <= stop_reason_d;
      first_q       <= first_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign Cmd_Ready   = (state_q == S_IDLE);
  assign Cpu_En      = cpu_en;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Stop_Reason = stop_reason_q;
  assign Cycle_Count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: vector table, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] cnt_in = '0;
  logic [3:0]  cnt4 = '0;
  logic        halt = 1'b0;
  logic [15:0] pc = '0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = '0;

  logic        ready, en, busy, done;
  logic [1:0]  reason;
  logic [15:0] ccnt;
  logic        ready4, en4, busy4, done4;
  logic [1:0]  reason4;
  logic [3:0]  ccnt4;

  cpu_run_ctrl u_dut (
    .Clock(clk), .Reset_n(rst_n), .Cmd_Valid(valid), .Cmd_Ready(ready),
    .Cmd_Op(op), .Cmd_Count(cnt_in), .Halt_Req(halt), .PC(pc),
    .Bp_Enable(bp_en), .Bp_Addr(bp_addr), .Cpu_En(en), .Busy(busy),
    .Done(done), .Stop_Reason(reason), .Cycle_Count(ccnt)
  );

  cpu_run_ctrl #(.CNT_W(4)) u_dut4 (
    .Clock(clk), .Reset_n(rst_n), .Cmd_Valid(valid), .Cmd_Ready(ready4),
    .Cmd_Op(op), .Cmd_Count(cnt4), .Halt_Req(halt), .PC(pc),
    .Bp_Enable(bp_en), .Bp_Addr(bp_addr), .Cpu_En(en4), .Busy(busy4),
    .Done(done4), .Stop_Reason(reason4), .Cycle_Count(ccnt4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: run flag, budget left (-1 = unlimited), counters
  bit m_run, m_first, m_done;
  int m_left, m_cnt, m_reason;
  int en_seen, done_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_first = 0; m_done = 0;
    m_left = 0; m_cnt = 0; m_reason = 0;
  endtask

  function automatic bit m_en();
    return m_run && !halt && !(bp_en && pc == bp_addr && !m_first);
  endfunction

  task automatic m_tick();
    bit e;
    e = m_en();
    m_done = 0;
    if (!m_run) begin
      if (valid && op != 2'd0) begin
        m_run = 1; m_cnt = 0; m_reason = 0; m_first = 1;
        if (op == 2'd1) m_left = -1;
        else if (op == 2'd3) m_left = 1;
        else m_left = (cnt_in == 0) ? 30 : int'(cnt_in);
      end
    end else if (halt) begin
      m_run = 0; m_reason = 3; m_done = 1;
    end else if (!e) begin
      m_run = 0; m_reason = 2; m_done = 1;
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      m_first = 0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_run = 0; m_reason = 1; m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    bit e;
    e = m_en();
    @(negedge clk);
    chk("cpu_en", int'(en), int'(e));
    chk("cmd_ready", int'(ready), int'(!m_run));
    if (en) en_seen++;
    @(posedge clk);
    m_tick();
    #1;
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("stop_reason", int'(reason), m_reason);
    chk("cycle_count", int'(ccnt), m_cnt);
    if (done) done_seen++;
  endtask

  typedef struct {
    bit       v;
    bit [1:0] op;
    int       cnt;
    bit       h;
    int       pc;
    bit       be;
    int       ba;
    bit       e_en;
    bit       e_busy;
    bit       e_done;
    int       e_rs;
    int       e_cc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 2'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 2'd0, 0, 0, 5, 0, 0, 1, 0, 1, 1, 1};
    tbl[2]  = '{0, 2'd0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 2'd0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{1, 2'd0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 2'd2, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 2'd1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    tbl[7]  = '{0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 2};
    tbl[8]  = '{1, 2'd1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 2'd0, 0, 0, 7, 1, 7, 1, 1, 0, 0, 1};
    tbl[10] = '{0, 2'd0, 0, 0, 7, 1, 7, 0, 0, 1, 2, 1};
    tbl[11] = '{1, 2'd3, 0, 0, 7, 1, 7, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 2'd0, 0, 0, 7, 1, 7, 1, 0, 1, 1, 1};
    tbl[13] = '{1, 2'd1, 0, 0, 7, 1, 7, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 2'd0, 0, 1, 7, 1, 7, 0, 0, 1, 3, 0};

    m_reset();
    #2;
    chk("rst_cpu_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_reason", int'(reason), 0);
    chk("rst_count", int'(ccnt), 0);
    chk("rst_ready", int'(ready), 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // vector table
    for (int i = 0; i < 15; i++) begin
      valid = tbl[i].v; op = tbl[i].op; cnt_in = 16'(tbl[i].cnt);
      halt = tbl[i].h; pc = 16'(tbl[i].pc);
      bp_en = tbl[i].be; bp_addr = 16'(tbl[i].ba);
      @(negedge clk);
      chk($sformatf("tbl%0d_en", i), int'(en), int'(tbl[i].e_en));
      @(posedge clk);
      m_tick();
      #1;
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_reason", i), int'(reason), tbl[i].e_rs);
      chk($sformatf("tbl%0d_count", i), int'(ccnt), tbl[i].e_cc);
    end
    valid = 0; halt = 0; bp_en = 0; pc = 0;
    step();

    // RUN_N 30 with a command held during the run
    en_seen = 0; done_seen = 0;
    valid = 1; op = 2'd2; cnt_in = 16'd30;
    step();
    op = 2'd3;
    repeat (5) step();
    valid = 0;
    repeat (35) step();
    chk("runn30_en_cycles", en_seen, 30);
    chk("runn30_dones", done_seen, 1);
    chk("runn30_reason", int'(reason), 1);
    chk("runn30_count", int'(ccnt), 30);

    // RUN_N with zero count uses the default, then STEP
    en_seen = 0;
    valid = 1; op = 2'd2; cnt_in = 16'd0;
    step(); valid = 0;
    repeat (35) step();
    chk("default_en_cycles", en_seen, 30);
    en_seen = 0;
    valid = 1; op = 2'd3;
    step(); valid = 0;
    repeat (4) step();
    chk("step_en_cycles", en_seen, 1);
    chk("step_count", int'(ccnt), 1);

    // breakpoint at 8 with PC following the enable, then resume by STEP
    pc = 0; bp_en = 1; bp_addr = 16'd8;
    valid = 1; op = 2'd1;
    step(); valid = 0;
    for (int k = 0; k < 20 && m_run; k++) begin
      step();
      if (en) pc = pc + 16'd1;
    end
    chk("bp_pc", int'(pc), 8);
    chk("bp_reason", int'(reason), 2);
    chk("bp_count", int'(ccnt), 8);
    en_seen = 0;
    valid = 1; op = 2'd3;
    step(); valid = 0;
    step();
    chk("bp_resume_en", en_seen, 1);
    chk("bp_resume_reason", int'(reason), 1);
    bp_en = 0;
    step();

    // halt at enabled cycle 12 of RUN_N 100
    en_seen = 0;
    valid = 1; op = 2'd2; cnt_in = 16'd100;
    step(); valid = 0;
    for (int k = 0; k < 30 && m_run; k++) begin
      halt = (en_seen == 12);
      step();
    end
    halt = 0;
    chk("halt_en_cycles", en_seen, 12);
    chk("halt_reason", int'(reason), 3);
    chk("halt_count", int'(ccnt), 12);

    // halt and breakpoint together: halt wins
    pc = 16'd3; bp_addr = 16'd3; bp_en = 1;
    valid = 1; op = 2'd1;
    step(); valid = 0;
    step();
    halt = 1;
    step();
    halt = 0; bp_en = 0;
    chk("halt_bp_reason", int'(reason), 3);
    step();

    // asynchronous reset mid RUN_FREE
    valid = 1; op = 2'd1;
    step(); valid = 0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_cpu_en", int'(en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_reason", int'(reason), 0);
    chk("mid_rst_count", int'(ccnt), 0);
    @(posedge clk); #1;
    chk("mid_rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // 4-bit counter saturation
    valid = 1; op = 2'd1;
    step(); valid = 0;
    repeat (20) step();
    chk("sat4_count", int'(ccnt4), 15);
    chk("sat4_busy", int'(busy4), 1);
    halt = 1;
    step();
    halt = 0;
    step();

    // random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      valid = ($urandom_range(0, 3) == 0);
      op = 2'($urandom_range(0, 3));
      cnt_in = 16'($urandom_range(0, 6));
      halt = ($urandom_range(0, 15) == 0);
      bp_en = 1'($urandom_range(0, 1));
      bp_addr = 16'($urandom_range(0, 7));
      pc = 16'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
